// File: rtl/matrix_p2s_serializer.sv
// Parallel-to-serial tile serializer: one N*N tile in, one element per beat out.
// Emits the top slice first; a pending slot lets the next tile load during drain.
module matrix_p2s_serializer #(
    parameter int DATA_WIDTH = 16,
    parameter int P2S_SIZE   = 3,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        i_valid,
    output logic                                        o_ready,
    input  logic [P2S_SIZE*P2S_SIZE*DATA_WIDTH-1:0]     i_matrix,
    output logic                                        o_valid,
    input  logic                                        i_ready,
    output logic [DATA_WIDTH-1:0]                       o_data,
    output logic                                        o_last,
    output logic                                        o_busy,
    output logic [CNT_WIDTH-1:0]                        o_tile_cnt
);

    localparam int NE = P2S_SIZE * P2S_SIZE;
    localparam int MW = NE * DATA_WIDTH;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                 state_q, state_d;
    logic [MW-1:0]          shift_q, shift_d;
    logic [MW-1:0]          pend_q, pend_d;
    logic                   pend_full_q, pend_full_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;

    logic load;
    logic beat;
    logic last;

    assign o_ready    = !rst && !pend_full_q;
    assign o_valid    = (state_q == SHIFT);
    assign last       = (idx_q == IW'(NE - 1));
    assign o_last     = o_valid && last;
    assign o_data     = shift_q[MW-1 -: DATA_WIDTH];
    assign o_busy     = (state_q == SHIFT) || pend_full_q;
    assign o_tile_cnt = cnt_q;

    assign load = i_valid && o_ready;
    assign beat = o_valid && i_ready;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    shift_d = i_matrix;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (beat && !last) begin
                    shift_d = shift_q << DATA_WIDTH;
                    idx_d   = idx_q + 1'b1;
                end else if (beat) begin
                    cnt_d = cnt_q + 1'b1;
                    idx_d = '0;
                    // Refill from pending first, else bypass a same-cycle load.
                    if (pend_full_q) begin
                        shift_d     = pend_q;
                        pend_full_d = 1'b0;
                    end else if (load) begin
                        shift_d = i_matrix;
                    end else begin
                        state_d = IDLE;
                    end
                end
                if (load && !(beat && last)) begin
                    pend_d      = i_matrix;
                    pend_full_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            idx_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_matrix_p2s_serializer.sv
// Bench for matrix_p2s_serializer: scoreboard of expected beats plus
// a tile table and hand sequences for overlap, bypass and reset.
module tb_matrix_p2s_serializer;

    localparam int DW = 16;
    localparam int NE = 9;
    localparam int MW = NE * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          o_ready;
    logic [MW-1:0] i_matrix;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic          o_last;
    logic          o_busy;
    logic [15:0]   o_tile_cnt;

    matrix_p2s_serializer #(
        .DATA_WIDTH(DW),
        .P2S_SIZE  (3),
        .CNT_WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_matrix  (i_matrix),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .o_last    (o_last),
        .o_busy    (o_busy),
        .o_tile_cnt(o_tile_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    typedef struct {
        logic [15:0] base;
        logic [15:0] step;
        int          mode;
        logic [15:0] exp_cnt;
    } vec_t;

    exp_t          sb[$];
    logic [DW-1:0] outlog[$];
    int            errors = 0;
    int            checks = 0;
    int            rdy_mode = 0;
    int            cyc = 0;
    int            vc = 0;
    int            rl = 0;
    int            first_v = -1;
    int            last_v = -1;
    logic [15:0]   exp_tiles = '0;

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    function automatic logic [MW-1:0] mk(input logic [15:0] b,
                                         input logic [15:0] s);
        logic [MW-1:0] m;
        logic [15:0]   kk;
        m = '0;
        for (int k = 0; k < NE; k++) begin
            kk = 16'(k);
            m[k*DW +: DW] = b + kk * s;
        end
        return m;
    endfunction

    // Ready driver
    initial begin
        int ph;
        ph = 0;
        i_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       i_ready = (ph % 4 == 0) || (ph % 4 == 3);
                2:       i_ready = 1'($urandom_range(0, 1));
                default: i_ready = 1'b1;
            endcase
            ph++;
        end
    end

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst) begin
            if (o_valid) begin
                vc++;
                if (first_v < 0) first_v = cyc;
                last_v = cyc;
                if (sb.size() == 0) begin
                    chk("spurious_valid", 32'(o_valid), 32'd0);
                end else begin
                    chk("beat_data", 32'(o_data), 32'(sb[0].d));
                    chk("beat_last", 32'(o_last), 32'(sb[0].l));
                    if (i_ready) begin
                        outlog.push_back(o_data);
                        if (sb[0].l) exp_tiles++;
                        void'(sb.pop_front());
                    end
                end
            end
            if (o_busy && !o_ready) rl++;
            if (i_valid && o_ready) begin
                for (int k = NE - 1; k >= 0; k--) begin
                    e.d = i_matrix[k*DW +: DW];
                    e.l = (k == 0);
                    sb.push_back(e);
                end
            end
        end
    end

    task automatic load(input logic [MW-1:0] m);
        bit ok;
        ok = 0;
        i_matrix = m;
        i_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (o_ready) ok = 1;
        end
        if (!ok) chk("load_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (!o_busy && !o_valid) ok = 1;
        end
        if (!ok) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[4];
        logic [MW-1:0] m;
        logic [DW-1:0] vals[NE];

        tbl[0] = '{base: 16'h0100, step: 16'h0001, mode: 0, exp_cnt: 16'd1};
        tbl[1] = '{base: 16'hA000, step: 16'h1111, mode: 1, exp_cnt: 16'd2};
        tbl[2] = '{base: 16'hFFFF, step: 16'hFFFF, mode: 2, exp_cnt: 16'd3};
        tbl[3] = '{base: 16'h0000, step: 16'h0F0F, mode: 1, exp_cnt: 16'd4};

        rst = 1'b1;
        i_valid = 1'b0;
        i_matrix = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_last", 32'(o_last), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_cnt", 32'(o_tile_cnt), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single tiles under different ready patterns
        for (int i = 0; i < 4; i++) begin
            rdy_mode = tbl[i].mode;
            m = mk(tbl[i].base, tbl[i].step);
            load(m);
            @(negedge clk);
            chk("lat_valid", 32'(o_valid), 32'd1);
            chk("lat_data", 32'(o_data), 32'(m[8*DW +: DW]));
            wait_idle();
            chk("tbl_cnt", 32'(o_tile_cnt), 32'(tbl[i].exp_cnt));
            chk("tbl_drained", 32'(sb.size()), 32'd0);
        end

        // Back-to-back tiles: no bubble, ready low while pending full
        rdy_mode = 0;
        @(posedge clk);
        #1;
        vc = 0;
        rl = 0;
        first_v = -1;
        load(mk(16'h2000, 16'h0003));
        load(mk(16'h3000, 16'h0005));
        wait_idle();
        chk("b2b_valid_cycles", 32'(vc), 32'd18);
        chk("b2b_span", 32'(last_v - first_v + 1), 32'd18);
        chk("b2b_ready_low", 32'(rl), 32'd8);
        chk("b2b_cnt", 32'(o_tile_cnt), 32'd6);

        // Same-cycle bypass on the last beat
        load(mk(16'h4000, 16'h0001));
        repeat (8) @(posedge clk);
        #1;
        m = mk(16'h5000, 16'h0002);
        i_matrix = m;
        i_valid = 1'b1;
        @(negedge clk);
        chk("byp_last", 32'(o_last), 32'd1);
        chk("byp_ready", 32'(o_ready), 32'd1);
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        @(negedge clk);
        chk("byp_valid", 32'(o_valid), 32'd1);
        chk("byp_data", 32'(o_data), 32'(m[8*DW +: DW]));
        chk("byp_ready_next", 32'(o_ready), 32'd1);
        wait_idle();
        chk("byp_cnt", 32'(o_tile_cnt), 32'd8);

        // Reset in the middle of a tile
        load(mk(16'h6000, 16'h0001));
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_tiles = '0;
        @(negedge clk);
        chk("mrst_valid", 32'(o_valid), 32'd0);
        chk("mrst_cnt", 32'(o_tile_cnt), 32'd0);
        chk("mrst_busy", 32'(o_busy), 32'd0);
        chk("mrst_data", 32'(o_data), 32'd0);
        @(posedge clk);
        #1;
        m = mk(16'h7000, 16'h0010);
        load(m);
        @(negedge clk);
        chk("mrst_first", 32'(o_data), 32'(m[8*DW +: DW]));
        wait_idle();
        chk("mrst_cnt_after", 32'(o_tile_cnt), 32'd1);

        // Round trip through an S2P shift-in model
        m = '0;
        for (int k = 0; k < NE; k++) begin
            vals[k] = 16'($urandom);
            m = (m << DW) | MW'(vals[k]);
        end
        outlog.delete();
        rdy_mode = 2;
        load(m);
        wait_idle();
        chk("rt_beats", 32'(outlog.size()), 32'd9);
        for (int k = 0; k < NE && k < outlog.size(); k++)
            chk("rt_order", 32'(outlog[k]), 32'(vals[k]));
        chk("model_cnt", 32'(o_tile_cnt), 32'(exp_tiles));
        chk("final_cnt", 32'(o_tile_cnt), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
